// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the counter, fetch, decode-handoff, redirect and
// run-control signals of the PC sequencer.
//   master modport : the sequencer side (drives strobes, mem_req, instr, status)
//   slave modport  : the environment side (counter, memory, decoder, run control)
//   WIDTH          : MSB index of every address (addresses are WIDTH+1 bits)
interface pc_sequencer_if #(
    parameter int WIDTH = 11
);
    logic [WIDTH:0] ctr_val;
    logic           ctr_load;
    logic           ctr_inc;
    logic [WIDTH:0] ctr_load_val;
    logic           mem_req;
    logic [WIDTH:0] mem_addr;
    logic           mem_ack;
    logic [15:0]    mem_rdata;
    logic           instr_valid;
    logic [15:0]    instr;
    logic           instr_ready;
    logic           jmp_en;
    logic [WIDTH:0] jmp_addr;
    logic           redirect_valid;
    logic [WIDTH:0] redirect_addr;
    logic           redirect_ready;
    logic           halt_req;
    logic           resume;
    logic           halted;
    logic           pc_wrap;

    modport master (
        input  ctr_val, mem_ack, mem_rdata, instr_ready, jmp_en, jmp_addr,
               redirect_valid, redirect_addr, halt_req, resume,
        output ctr_load, ctr_inc, ctr_load_val, mem_req, mem_addr, instr_valid,
               instr, redirect_ready, halted, pc_wrap
    );

    modport slave (
        output ctr_val, mem_ack, mem_rdata, instr_ready, jmp_en, jmp_addr,
               redirect_valid, redirect_addr, halt_req, resume,
        input  ctr_load, ctr_inc, ctr_load_val, mem_req, mem_addr, instr_valid,
               instr, redirect_ready, halted, pc_wrap
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer that boots an external counter,
// fetches instructions, hands them to the decoder and handles jumps,
// redirects and halt/resume.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pc_sequencer_if.master (counter strobes, fetch handshake,
//           decoder handoff, redirect handshake, run control)
// Only instr is registered; every other output is decoded from state and inputs.
module pc_sequencer #(
    parameter int             WIDTH     = 11,
    parameter logic [WIDTH:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {RST, BOOT, FETCH, DISPATCH, HALT} state_t;

    state_t         state_q, state_d;
    logic [15:0]    instr_q, instr_d;
    logic           halt_pend_q, halt_pend_d;
    logic           ctr_load, ctr_inc, mem_req, instr_valid;
    logic           redirect_ready, halted, halt_now;
    logic [WIDTH:0] ctr_load_val, mem_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST;
            instr_q     <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // A halt request seen while running is remembered so a short pulse in
    // FETCH still stops the core after the next dispatch handshake.
    assign halt_now = bus.halt_req | halt_pend_q;

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        ctr_load       = 1'b0;
        ctr_inc        = 1'b0;
        ctr_load_val   = '0;
        mem_req        = 1'b0;
        mem_addr       = '0;
        instr_valid    = 1'b0;
        redirect_ready = 1'b0;
        halted         = 1'b0;
        unique case (state_q)
            RST: state_d = BOOT;
            BOOT: begin
                ctr_load     = 1'b1;
                ctr_load_val = RESET_VEC;
                state_d      = FETCH;
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = bus.ctr_val;
                if (bus.mem_ack) begin
                    instr_d = bus.mem_rdata;
                    state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                // A redirect wins over the decoder handshake and drops the
                // fetched instruction.
                if (bus.redirect_valid) begin
                    redirect_ready = 1'b1;
                    ctr_load       = 1'b1;
                    ctr_load_val   = bus.redirect_addr;
                    state_d        = halt_now ? HALT : FETCH;
                end else begin
                    instr_valid = 1'b1;
                    if (bus.instr_ready) begin
                        ctr_load     = bus.jmp_en;
                        ctr_inc      = !bus.jmp_en;
                        ctr_load_val = bus.jmp_en ? bus.jmp_addr : '0;
                        state_d      = halt_now ? HALT : FETCH;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
                if (bus.redirect_valid) begin
                    redirect_ready = 1'b1;
                    ctr_load       = 1'b1;
                    ctr_load_val   = bus.redirect_addr;
                end
                if (bus.resume) state_d = FETCH;
            end
            default: state_d = RST;
        endcase
        halt_pend_d = (state_d == HALT || state_q == HALT) ? 1'b0 :
                      halt_pend_q | (bus.halt_req & (state_q == FETCH || state_q == DISPATCH));
    end

    assign bus.ctr_load       = ctr_load;
    assign bus.ctr_inc        = ctr_inc;
    assign bus.ctr_load_val   = ctr_load_val;
    assign bus.mem_req        = mem_req;
    assign bus.mem_addr       = mem_addr;
    assign bus.instr_valid    = instr_valid;
    assign bus.instr          = instr_q;
    assign bus.redirect_ready = redirect_ready;
    assign bus.halted         = halted;
    assign bus.pc_wrap        = ctr_inc & (&bus.ctr_val);
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11, the MSB index of every address (address width WIDTH+1 = 12 bits).
REQ-002 The block SHALL have parameter RESET_VEC, default 0, the address loaded into the PC after reset.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 ctr_val  in  WIDTH+1  current PC value from the external counter.
REQ-006 ctr_load / ctr_inc / ctr_load_val  out  1 / 1 / WIDTH+1  counter load strobe, increment strobe and load value.
REQ-007 mem_req  out  1, mem_addr  out  WIDTH+1, mem_ack  in  1, mem_rdata  in  16  instruction-fetch handshake.
REQ-008 instr_valid  out  1, instr  out  16, instr_ready  in  1  instruction handoff to the decoder.
REQ-009 jmp_en  in  1, jmp_addr  in  WIDTH+1  branch target, sampled only in the instr handshake cycle.
REQ-010 redirect_valid  in  1, redirect_addr  in  WIDTH+1, redirect_ready  out  1  external PC redirect.
REQ-011 halt_req  in  1, resume  in  1, halted  out  1, pc_wrap  out  1  run control and wrap flag.

Function
REQ-012 States SHALL be RST, BOOT, FETCH, DISPATCH and HALT.
REQ-013 RST SHALL drive all outputs 0 and go to BOOT unconditionally on the next edge.
REQ-014 BOOT SHALL assert ctr_load=1 with ctr_load_val=RESET_VEC for exactly one cycle, then go to FETCH.
REQ-015 FETCH SHALL hold mem_req=1 and mem_addr=ctr_val until mem_ack=1; on the ack edge instr SHALL latch mem_rdata and the state SHALL go to DISPATCH.
REQ-016 mem_req SHALL never drop before mem_ack; FETCH SHALL NOT be aborted by redirect or halt.
REQ-017 DISPATCH SHALL hold instr_valid=1 with instr stable until instr_ready=1.
REQ-018 DISPATCH handshake cycle: if jmp_en=1, ctr_load=1 and ctr_load_val=jmp_addr; otherwise ctr_inc=1.
REQ-019 After a DISPATCH handshake the next state SHALL be HALT if halt_req=1, otherwise FETCH.
REQ-020 redirect_valid in DISPATCH SHALL take priority over instr_ready: redirect_ready=1, ctr_load=1, ctr_load_val=redirect_addr, instr_valid=0 that cycle, and the instruction is discarded; the next state SHALL be FETCH, or HALT if halt_req=1.
REQ-021 redirect_valid in HALT SHALL assert redirect_ready=1 and ctr_load=redirect_addr, and the block SHALL stay in HALT.
REQ-022 redirect_valid in RST, BOOT or FETCH SHALL be held off with redirect_ready=0.
REQ-023 halt_req in FETCH SHALL take effect after the following DISPATCH handshake; in HALT, halted=1 and no strobes are issued except a redirect load.
REQ-024 HALT SHALL go to FETCH on resume=1; if resume and redirect_valid coincide, the load SHALL occur and the next state SHALL be FETCH.
REQ-025 ctr_load and ctr_inc SHALL never be asserted in the same cycle.
REQ-026 pc_wrap SHALL pulse 1 in any cycle with ctr_inc=1 and ctr_val all-ones; the PC wraps to 0 and the sequencer continues normally.
REQ-027 All outputs other than instr SHALL be combinational from state and inputs; instr SHALL be registered.

Reset
REQ-028 rst_n=0 SHALL force state RST and instr=0 immediately, and all outputs SHALL be 0 while it is asserted, including mid-fetch with a pending mem_ack.
REQ-029 After rst_n rises, the first ctr_load SHALL occur in the second cycle (the BOOT state).

Verification
REQ-030 Reset release with RESET_VEC=0x100 -> ctr_load=1, val 0x100 in cycle 2; mem_req with addr 0x100 in cycle 3.
REQ-031 Fetch at 0x100, mem_ack delayed 3 cycles, rdata 0xBEEF, instr_ready immediate -> instr=0xBEEF, one ctr_inc, next fetch at 0x101.
REQ-032 DISPATCH at 0x101 with jmp_en=1, jmp_addr=0x7F0 -> ctr_load with 0x7F0, no ctr_inc, next mem_addr 0x7F0.
REQ-033 ctr_val=0xFFF, no jump -> ctr_inc=1 with pc_wrap=1, next fetch at 0x000.
REQ-034 redirect_valid with 0x040 during FETCH -> redirect_ready stays 0 until DISPATCH; then load 0x040, instruction dropped, fetch at 0x040.
REQ-035 halt_req during FETCH -> one dispatch, then halted=1 with no strobes; resume -> fetch resumes at the incremented PC; rst_n low mid-FETCH -> mem_req=0 at once.
